// File: rtl/miriscv_cu_pkg.sv
// Shared control-unit types: operand bypass select codes, result-source codes
// and the shadow-pipeline entry used by the hazard unit.
package miriscv_cu_pkg;

  typedef enum logic [1:0] {
    NO_BYPASS = 2'd0,
    BYPASS_E  = 2'd1,
    BYPASS_M  = 2'd2,
    BYPASS_W  = 2'd3
  } bypass_sel_e;

  localparam logic [1:0] RES_SRC_ALU  = 2'd0;
  localparam logic [1:0] RES_SRC_MEM  = 2'd1;
  localparam logic [1:0] RES_SRC_LONG = 2'd2;

  localparam int unsigned SHADOW_RD_W = 5;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [SHADOW_RD_W-1:0] rd;
    logic [1:0]             res_src;
  } shadow_entry_t;

  // Code 3 is unassigned; treat it as the slowest source so it can never forward early.
  function automatic logic [1:0] norm_res_src(input logic [1:0] src);
    return (src == 2'd3) ? RES_SRC_LONG : src;
  endfunction

endpackage

// File: rtl/miriscv_bypass_match.sv
// Per-operand RAW matcher: picks the youngest E/M/W producer of the source
// register and returns {bypass code, stall}. Honours MIRISCV_HAZARD_BYPASS_EN.
module miriscv_bypass_match
  import miriscv_cu_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 used_i,
  input  logic [RF_ADDR_W-1:0] addr_i,
  input  shadow_entry_t        e_entry_i,
  input  shadow_entry_t        m_entry_i,
  input  shadow_entry_t        w_entry_i,
  output logic [1:0]           bypass_o,
  output logic                 stall_o
);

  logic [SHADOW_RD_W-1:0] addrCmp;
  logic                   srcActive;
  logic                   hitE;
  logic                   hitM;
  logic                   hitW;
  logic                   unusedResSrc;

  assign addrCmp   = SHADOW_RD_W'(addr_i);
  assign srcActive = used_i & (addr_i != '0);
  assign hitE      = e_entry_i.valid & e_entry_i.we & (e_entry_i.rd == addrCmp);
  assign hitM      = m_entry_i.valid & m_entry_i.we & (m_entry_i.rd == addrCmp);
  assign hitW      = w_entry_i.valid & w_entry_i.we & (w_entry_i.rd == addrCmp);

  // A W-stage result is always ready, so its source code never matters.
  assign unusedResSrc = ^w_entry_i.res_src;

`ifdef MIRISCV_HAZARD_BYPASS_EN
  // Younger stages shadow older ones; forward only once the result exists.
  always_comb begin
    bypass_o = NO_BYPASS;
    stall_o  = 1'b0;
    if (srcActive) begin
      if (hitE) begin
        if (e_entry_i.res_src == RES_SRC_ALU) bypass_o = BYPASS_E;
        else                                  stall_o  = 1'b1;
      end else if (hitM) begin
        if (m_entry_i.res_src == RES_SRC_LONG) stall_o  = 1'b1;
        else                                   bypass_o = BYPASS_M;
      end else if (hitW) begin
        bypass_o = BYPASS_W;
      end
    end
  end
`else
  logic unusedEmSrc;

  assign unusedEmSrc = ^{e_entry_i.res_src, m_entry_i.res_src};

  // Without forwarding, any in-flight producer blocks until it has retired.
  always_comb begin
    bypass_o = NO_BYPASS;
    stall_o  = srcActive & (hitE | hitM | hitW);
  end
`endif

endmodule

// File: rtl/miriscv_hazard_unit.sv
// RAW hazard resolution for the D-stage instruction over an E/M/W shadow pipeline.
// Forwarding is enabled by defining MIRISCV_HAZARD_BYPASS_EN; otherwise hazards stall.
module miriscv_hazard_unit
  import miriscv_cu_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 d_valid_i,
  input  logic [RF_ADDR_W-1:0] d_rs1_addr_i,
  input  logic                 d_rs1_used_i,
  input  logic [RF_ADDR_W-1:0] d_rs2_addr_i,
  input  logic                 d_rs2_used_i,
  input  logic [RF_ADDR_W-1:0] d_rd_addr_i,
  input  logic                 d_rd_we_i,
  input  logic [1:0]           d_res_src_i,
  input  logic                 mem_stall_i,
  input  logic                 kill_i,
  output logic [1:0]           op1_bypass_o,
  output logic [1:0]           op2_bypass_o,
  output logic                 hazard_stall_o
);

  shadow_entry_t eEntry_q;
  shadow_entry_t mEntry_q;
  shadow_entry_t wEntry_q;
  shadow_entry_t eEntry_d;

  logic [1:0] op1Sel;
  logic [1:0] op2Sel;
  logic       op1Stall;
  logic       op2Stall;
  logic       dActive;
  logic       dIssue;

  miriscv_bypass_match #(.RF_ADDR_W(RF_ADDR_W)) u_rs1_match (
    .used_i    (d_rs1_used_i),
    .addr_i    (d_rs1_addr_i),
    .e_entry_i (eEntry_q),
    .m_entry_i (mEntry_q),
    .w_entry_i (wEntry_q),
    .bypass_o  (op1Sel),
    .stall_o   (op1Stall)
  );

  miriscv_bypass_match #(.RF_ADDR_W(RF_ADDR_W)) u_rs2_match (
    .used_i    (d_rs2_used_i),
    .addr_i    (d_rs2_addr_i),
    .e_entry_i (eEntry_q),
    .m_entry_i (mEntry_q),
    .w_entry_i (wEntry_q),
    .bypass_o  (op2Sel),
    .stall_o   (op2Stall)
  );

  assign dActive        = d_valid_i & ~kill_i;
  assign hazard_stall_o = dActive & (op1Stall | op2Stall);
  assign dIssue         = dActive & ~hazard_stall_o;

  // A stalled or squashed operand must not steer the mux to stale data.
  assign op1_bypass_o = dIssue ? op1Sel : NO_BYPASS;
  assign op2_bypass_o = dIssue ? op2Sel : NO_BYPASS;

  always_comb begin
    eEntry_d = '0;
    if (dIssue) begin
      eEntry_d.valid   = 1'b1;
      eEntry_d.we      = d_rd_we_i & (d_rd_addr_i != '0);
      eEntry_d.rd      = SHADOW_RD_W'(d_rd_addr_i);
      eEntry_d.res_src = norm_res_src(d_res_src_i);
    end
  end

  // The LSU freeze overrides everything else, including kills and bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eEntry_q <= '0;
      mEntry_q <= '0;
      wEntry_q <= '0;
    end else if (!mem_stall_i) begin
      eEntry_q <= eEntry_d;
      mEntry_q <= eEntry_q;
      wEntry_q <= mEntry_q;
    end
  end

endmodule

// File: tb/tb_miriscv_hazard_unit.sv
// Self-checking bench for miriscv_hazard_unit: directed vectors with literal
// expectations plus a queue-based model checked every cycle. Follows MIRISCV_HAZARD_BYPASS_EN.
module tb_miriscv_hazard_unit;
  import miriscv_cu_pkg::*;

`ifdef MIRISCV_HAZARD_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       d_valid_i;
  logic [4:0] d_rs1_addr_i;
  logic       d_rs1_used_i;
  logic [4:0] d_rs2_addr_i;
  logic       d_rs2_used_i;
  logic [4:0] d_rd_addr_i;
  logic       d_rd_we_i;
  logic [1:0] d_res_src_i;
  logic       mem_stall_i;
  logic       kill_i;
  logic [1:0] op1_bypass_o;
  logic [1:0] op2_bypass_o;
  logic       hazard_stall_o;

  int numVectors = 0;
  int numMiscompares = 0;

  typedef struct {
    bit valid;
    bit we;
    int rd;
    int src;
  } modelEntry_t;

  // pipe[0] is E, pipe[1] is M, pipe[2] is W.
  modelEntry_t pipe[$];

  miriscv_hazard_unit #(.RF_ADDR_W(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .d_valid_i      (d_valid_i),
    .d_rs1_addr_i   (d_rs1_addr_i),
    .d_rs1_used_i   (d_rs1_used_i),
    .d_rs2_addr_i   (d_rs2_addr_i),
    .d_rs2_used_i   (d_rs2_used_i),
    .d_rd_addr_i    (d_rd_addr_i),
    .d_rd_we_i      (d_rd_we_i),
    .d_res_src_i    (d_res_src_i),
    .mem_stall_i    (mem_stall_i),
    .kill_i         (kill_i),
    .op1_bypass_o   (op1_bypass_o),
    .op2_bypass_o   (op2_bypass_o),
    .hazard_stall_o (hazard_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    modelEntry_t bubble;
    bubble = '{valid: 1'b0, we: 1'b0, rd: 0, src: 0};
    pipe.delete();
    repeat (3) pipe.push_back(bubble);
  endfunction

  // A result is usable from the stage index where it is produced: ALU in E, MEM in M, LONG in W.
  function automatic void modelOperand(input int addr, input bit used, output logic [1:0] code, output bit stall);
    int readyAt;
    code  = NO_BYPASS;
    stall = 1'b0;
    if (!used || addr == 0) return;
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].valid && pipe[i].we && pipe[i].rd == addr) begin
        readyAt = (pipe[i].src == 0) ? 0 : (pipe[i].src == 1) ? 1 : 2;
        if (BypassEn && i >= readyAt)
          code = (i == 0) ? BYPASS_E : (i == 1) ? BYPASS_M : BYPASS_W;
        else
          stall = 1'b1;
        return;
      end
    end
  endfunction

  function automatic void modelExpect(output logic [1:0] e1, output logic [1:0] e2, output logic es);
    logic [1:0] c1, c2;
    bit s1, s2, active;
    modelOperand(int'(d_rs1_addr_i), d_rs1_used_i, c1, s1);
    modelOperand(int'(d_rs2_addr_i), d_rs2_used_i, c2, s2);
    active = d_valid_i && !kill_i;
    es = active && (s1 || s2);
    e1 = (active && !es) ? c1 : NO_BYPASS;
    e2 = (active && !es) ? c2 : NO_BYPASS;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin : modelUpdate
    logic [1:0] e1, e2;
    logic es;
    modelEntry_t n;
    if (rst_i) begin
      modelReset();
    end else if (!mem_stall_i) begin
      modelExpect(e1, e2, es);
      n = '{valid: 1'b0, we: 1'b0, rd: 0, src: 0};
      if (d_valid_i && !kill_i && !es)
        n = '{valid: 1'b1, we: d_rd_we_i, rd: int'(d_rd_addr_i), src: int'(d_res_src_i)};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  end

  always @(negedge clk_i) begin : compareProc
    logic [1:0] e1, e2;
    logic es;
    modelExpect(e1, e2, es);
    checkOutput("model.op1", op1_bypass_o, e1);
    checkOutput("model.op2", op2_bypass_o, e2);
    checkOutput("model.stall", {1'b0, hazard_stall_o}, {1'b0, es});
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic we, input logic [1:0] src, input logic ms, input logic kl);
    @(posedge clk_i);
    #1;
    d_valid_i    = v;
    d_rs1_addr_i = rs1;
    d_rs1_used_i = u1;
    d_rs2_addr_i = rs2;
    d_rs2_used_i = u2;
    d_rd_addr_i  = rd;
    d_rd_we_i    = we;
    d_res_src_i  = src;
    mem_stall_i  = ms;
    kill_i       = kl;
  endtask

  task automatic issueOp(input logic [4:0] rd, input logic [1:0] src);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, src, 1'b0, 1'b0);
  endtask

  task automatic readOp(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd);
    applyStimulus(1'b1, rs1, u1, rs2, u2, rd, 1'b1, RES_SRC_ALU, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, RES_SRC_ALU, 1'b0, 1'b0);
  endtask

  // Literal expectation pair: first triple for the forwarding build, second for the stall-only build.
  task automatic expectNow(input string name,
                           input logic [1:0] bp1, input logic [1:0] bp2, input logic bps,
                           input logic [1:0] nb1, input logic [1:0] nb2, input logic nbs);
    #1;
    checkOutput({name, ".op1"}, op1_bypass_o, BypassEn ? bp1 : nb1);
    checkOutput({name, ".op2"}, op2_bypass_o, BypassEn ? bp2 : nb2);
    checkOutput({name, ".stall"}, {1'b0, hazard_stall_o}, {1'b0, BypassEn ? bps : nbs});
  endtask

  initial begin
    modelReset();
    rst_i        = 1'b1;
    d_valid_i    = 1'b1;
    d_rs1_addr_i = 5'd5;
    d_rs1_used_i = 1'b1;
    d_rs2_addr_i = 5'd0;
    d_rs2_used_i = 1'b0;
    d_rd_addr_i  = 5'd0;
    d_rd_we_i    = 1'b0;
    d_res_src_i  = RES_SRC_ALU;
    mem_stall_i  = 1'b0;
    kill_i       = 1'b0;
    #1;
    expectNow("reset", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    idle(1);

    // Back-to-back ALU dependency walking through E, M, W.
    issueOp(5'd5, RES_SRC_ALU);
    readOp(5'd5, 1'b1, 5'd0, 1'b0, 5'd10);
    expectNow("aluE", BYPASS_E, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd5, 1'b1, 5'd0, 1'b0, 5'd11);
    expectNow("aluM", BYPASS_M, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd5, 1'b1, 5'd0, 1'b0, 5'd12);
    expectNow("aluW", BYPASS_W, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd5, 1'b1, 5'd0, 1'b0, 5'd0);
    expectNow("aluNone", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    idle(3);

    // Load-use.
    issueOp(5'd7, RES_SRC_MEM);
    readOp(5'd0, 1'b0, 5'd7, 1'b1, 5'd8);
    expectNow("loadUse", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd0, 1'b0, 5'd7, 1'b1, 5'd8);
    expectNow("loadUseM", NO_BYPASS, BYPASS_M, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    idle(3);

    // Long-latency producer.
    issueOp(5'd9, RES_SRC_LONG);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    expectNow("longE", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    expectNow("longM", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    expectNow("longW", BYPASS_W, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    idle(3);

    // Long producer (code 3) with a three-cycle LSU freeze while it sits in M.
    issueOp(5'd9, 2'd3);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, RES_SRC_ALU, 1'b1, 1'b0);
    expectNow("frozenM", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, RES_SRC_ALU, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, RES_SRC_ALU, 1'b1, 1'b0);
    expectNow("frozenHeld", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    expectNow("thawedM", NO_BYPASS, NO_BYPASS, 1'b1, NO_BYPASS, NO_BYPASS, 1'b1);
    readOp(5'd9, 1'b1, 5'd0, 1'b0, 5'd1);
    expectNow("thawedW", BYPASS_W, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    idle(3);

    // x0 never matches; younger stage wins.
    issueOp(5'd0, RES_SRC_ALU);
    readOp(5'd0, 1'b1, 5'd0, 1'b1, 5'd13);
    expectNow("x0", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    idle(3);
    issueOp(5'd3, RES_SRC_ALU);
    issueOp(5'd20, RES_SRC_ALU);
    issueOp(5'd3, RES_SRC_ALU);
    readOp(5'd0, 1'b0, 5'd3, 1'b1, 5'd22);
    expectNow("prioEW", NO_BYPASS, BYPASS_E, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    idle(3);
    issueOp(5'd3, RES_SRC_ALU);
    issueOp(5'd3, RES_SRC_MEM);
    idle(1);
    readOp(5'd3, 1'b1, 5'd0, 1'b0, 5'd23);
    expectNow("prioMW", BYPASS_M, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    idle(3);

    // Kill and invalid D.
    issueOp(5'd4, RES_SRC_MEM);
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, RES_SRC_ALU, 1'b0, 1'b1);
    expectNow("kill", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    readOp(5'd4, 1'b1, 5'd0, 1'b0, 5'd15);
    expectNow("afterKill", BYPASS_M, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b1);
    applyStimulus(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, RES_SRC_ALU, 1'b0, 1'b0);
    expectNow("dInvalid", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    idle(3);

    // Reset in the middle of a hazard.
    issueOp(5'd6, RES_SRC_MEM);
    readOp(5'd6, 1'b1, 5'd0, 1'b0, 5'd16);
    #2 rst_i = 1'b1;
    expectNow("resetMid", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    expectNow("afterReset", NO_BYPASS, NO_BYPASS, 1'b0, NO_BYPASS, NO_BYPASS, 1'b0);

    // Mixed traffic over a small register window, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 5) != 0),
                    5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 7) == 0));
    end
    idle(3);
    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/miriscv_hazard_unit.md
Name: miriscv_hazard_unit

Overview:
- Producer side of the operand-bypass select codes (NO_BYPASS/BYPASS_E/BYPASS_M/BYPASS_W) consumed by the decode-stage operand muxes.
- Keeps a shadow pipeline of destination-register info for the E, M and W stages.
- Resolves RAW hazards for the instruction in D: either selects the youngest forwarding source or asserts a load-use/long-latency stall.
- Sits in the control unit beside the decoder.

Parameters:
- RF_ADDR_W, 5, register-file address width; register 0 is hardwired zero.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- d_valid_i  in  1  D stage holds a valid instruction
- d_rs1_addr_i  in  RF_ADDR_W  source 1 address
- d_rs1_used_i  in  1  instruction reads rs1
- d_rs2_addr_i  in  RF_ADDR_W  source 2 address
- d_rs2_used_i  in  1  instruction reads rs2
- d_rd_addr_i  in  RF_ADDR_W  destination address
- d_rd_we_i  in  1  instruction writes rd
- d_res_src_i  in  2  result source: RES_SRC_ALU / RES_SRC_MEM / RES_SRC_LONG
- mem_stall_i  in  1  LSU stall; freezes the whole pipeline
- kill_i  in  1  squash the D instruction (branch/jump redirect)
- op1_bypass_o  out  2  operand 1 bypass select
- op2_bypass_o  out  2  operand 2 bypass select
- hazard_stall_o  out  1  hold F/D and inject a bubble into E

Behaviour:
- Clock/reset: one clock (clk_i). Reset is asynchronous and active-high (rst_i).
- Reset state: E/M/W shadow entries invalid. Outputs then read NO_BYPASS, NO_BYPASS, 0.
- Shadow entry fields: valid, we, rd, res_src.
  - A captured entry with rd==0 has we forced to 0.
  - RES_SRC code 3 is treated as RES_SRC_LONG.
- Outputs are purely combinational from D inputs and shadow state: zero-cycle latency, no registered outputs.
- Per-operand match, for an operand with used=1 and addr!=0:
  - Find the youngest of E, M, W with valid & we & rd==addr.
  - No match -> NO_BYPASS.
  - Match in E: ALU -> BYPASS_E; MEM or LONG -> stall.
  - Match in M: ALU or MEM -> BYPASS_M; LONG -> stall.
  - Match in W -> BYPASS_W (any source).
  - Younger stage always wins, e.g. E and W both match with an ALU op in E -> BYPASS_E.
- hazard_stall_o = d_valid_i & ~kill_i & (either operand requires stall).
  - While asserted, both bypass outputs read NO_BYPASS.
- d_valid_i=0 or kill_i=1: no stall; both bypass outputs read NO_BYPASS.
- Advance on each rising edge, unless frozen:
  - W<=M, M<=E.
  - E <= D info when d_valid_i & ~kill_i & ~hazard_stall_o; otherwise a bubble (valid=0).
- mem_stall_i=1: all shadow entries hold. Combinational outputs still computed from the held state.
- mem_stall_i has priority over kill_i and hazard stall for the shadow update.
- The W entry drops out on the next advance. The register file is not write-through, so W forwarding covers the write cycle.
- Reset mid-operation: all entries are cleared immediately (asynchronous). No in-flight hazard survives reset.

Optional Feature:
- Macro: MIRISCV_HAZARD_BYPASS_EN.
- Defined: forwarding as described above.
- Undefined: both bypass outputs are tied to NO_BYPASS. Any match in E, M or W for a used nonzero source asserts hazard_stall_o until that entry has left W. Shadow pipeline and port list are identical in both builds.

Decomposition:
- Bypass codes stay in miriscv_cu_pkg.
- Add to the same package: RES_SRC_ALU=2'd0, RES_SRC_MEM=2'd1, RES_SRC_LONG=2'd2, plus a packed struct type for a shadow entry (valid, we, rd, res_src).
- One sub-module: miriscv_bypass_match.
  - Combinational per-operand priority matcher producing {bypass code, stall}.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
- Back-to-back ALU dependency: ALU x5 in E, then D reads rs1=x5 -> op1_bypass_o=BYPASS_E, stall 0. Next cycle (x5 in M, unrelated op in E) -> BYPASS_M. Next -> BYPASS_W. Then NO_BYPASS.
- Load-use: MEM x7 in E, D reads rs2=x7 -> hazard_stall_o=1 for exactly 1 cycle, E bubble. Next cycle op2_bypass_o=BYPASS_M.
- Long op: LONG x9 in E, D reads x9 -> stall 2 cycles, then BYPASS_W. With mem_stall_i=1 for 3 cycles mid-sequence, stall extends by 3 and shadow state is held.
- x0 and priority: rd=x0 writes never match (NO_BYPASS). ALU x3 in E and ALU x3 in W, D reads x3 -> BYPASS_E.
- kill/reset: kill_i=1 with MEM x4 in E and D reading x4 -> stall 0, next E bubble. rst_i pulsed mid-stream -> outputs NO_BYPASS/0 in the same cycle, all entries invalid.
- Macro undefined: ALU x5 in E, D reads x5 -> stall for 3 cycles, bypass outputs always NO_BYPASS.
